// File: rtl/gpio_chkmon_pkg.sv
// gpio_chkmon_pkg: shared types and constants for the checkpoint monitor.
package gpio_chkmon_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Consecutive identical samples required per match when the stable filter is built in.
   localparam int STABLE_CYCLES = 2;

endpackage

// File: rtl/gpio_chkmon_timer.sv
// gpio_chkmon_timer: run-time cycle counter for the checkpoint monitor.
// Cleared and loaded with the limit on arm, counts (saturating) while run is
// high, holds otherwise. expire flags the edge on which the count becomes
// equal to a non-zero limit.
module gpio_chkmon_timer #(
   parameter int TMO_W = 32
) (
   input  logic             clock,
   input  logic             resetb,
   input  logic             clear,
   input  logic             run,
   input  logic [TMO_W-1:0] lim_in,
   output logic [TMO_W-1:0] count,
   output logic             expire
);

   logic [TMO_W-1:0] lim;
   logic [TMO_W-1:0] count_inc;

   assign count_inc = (count == '1) ? count : count + TMO_W'(1);
   assign expire    = run && (lim != '0) && (count_inc == lim);

   // Load limit on arm, advance the counter while running, freeze otherwise.
   always_ff @(posedge clock) begin
      if (!resetb) begin
         count <= '0;
         lim   <= '0;
      end else if (clear) begin
         count <= '0;
         lim   <= lim_in;
      end else if (run) begin
         count <= count_inc;
      end
   end

endmodule

// File: rtl/gpio_checkpoint_monitor.sv
// gpio_checkpoint_monitor: watches a status bus for a programmed sequence of
// checkpoint codes, with an optional global cycle timeout.
// Build option: define GPIO_CHKMON_STABLE_EN to require each code to be seen
// on STABLE_CYCLES consecutive samples (hit latency 3 instead of 2).
module gpio_checkpoint_monitor #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4,
   parameter int TMO_W = 32
) (
   input  logic                       clock,
   input  logic                       resetb,
   input  logic [WIDTH-1:0]           check_i,
   input  logic                       start,
   input  logic [$clog2(DEPTH+1)-1:0] num_steps,
   input  logic [TMO_W-1:0]           tmo_lim,
   input  logic                       exp_we,
   input  logic [$clog2(DEPTH)-1:0]   exp_addr,
   input  logic [WIDTH-1:0]           exp_data,
   output logic                       busy,
   output logic                       pass,
   output logic                       fail,
   output logic                       hit,
   output logic [$clog2(DEPTH+1)-1:0] step_idx,
   output logic [TMO_W-1:0]           cycles
);

   import gpio_chkmon_pkg::*;

   localparam int SW = $clog2(DEPTH + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef GPIO_CHKMON_STABLE_EN
   localparam int HIST_N = STABLE_CYCLES;
`else
   localparam int HIST_N = 1;
`endif

   state_t           state;
   logic [SW-1:0]    steps_lat;
   logic             consumed;
   logic [WIDTH-1:0] last_code;

   logic [WIDTH-1:0] exp_tab [DEPTH];
   logic [WIDTH-1:0] exp_cur;
   logic [AW-1:0]    rd_idx;

   logic [WIDTH-1:0] hist [HIST_N];
   logic [WIDTH-1:0] chk_q;
   logic [HIST_N-1:0] eq_vec;
   logic             seen;
   logic             match;
   logic [SW-1:0]    step_next;
   logic             arm_ok;
   logic             expire;

   genvar gi;

   // Sample the bus (and, with the stable filter, its recent history).
   always_ff @(posedge clock) begin
      if (!resetb) begin
         for (int i = 0; i < HIST_N; i++) hist[i] <= '0;
      end else begin
         hist[0] <= check_i;
         for (int i = 1; i < HIST_N; i++) hist[i] <= hist[i-1];
      end
   end

   assign chk_q = hist[0];

   generate
      for (gi = 0; gi < HIST_N; gi++) begin : g_eq
         assign eq_vec[gi] = (hist[gi] == exp_cur);
      end
   endgenerate

   // A code only counts once: after a match, the bus must move away from it
   // before the same value can satisfy the next entry.
   assign seen      = &eq_vec;
   assign match     = (state == ARMED) && seen && !(consumed && (chk_q == last_code));
   assign step_next = step_idx + SW'(1);
   assign arm_ok    = start && (state != ARMED);

   // Table address for the registered read: entry 0 on arm, next entry on a match.
   always_comb begin
      rd_idx = step_idx[AW-1:0];
      if (arm_ok) begin
         rd_idx = '0;
      end else if (match) begin
         rd_idx = AW'(step_next);
      end
   end

   // Expected-code table: writes only while not armed, registered read of the current entry.
   always_ff @(posedge clock) begin
      if (exp_we && !busy) exp_tab[AW'(exp_addr)] <= exp_data;
      exp_cur <= exp_tab[rd_idx];
   end

   gpio_chkmon_timer #(
      .TMO_W (TMO_W)
   ) u_timer (
      .clock  (clock),
      .resetb (resetb),
      .clear  (arm_ok),
      .run    (state == ARMED),
      .lim_in (tmo_lim),
      .count  (cycles),
      .expire (expire)
   );

   // Sequencer: arm, step through the table, resolve to pass or timeout fail.
   always_ff @(posedge clock) begin
      if (!resetb) begin
         state     <= IDLE;
         busy      <= 1'b0;
         pass      <= 1'b0;
         fail      <= 1'b0;
         hit       <= 1'b0;
         step_idx  <= '0;
         steps_lat <= '0;
         consumed  <= 1'b0;
         last_code <= '0;
      end else begin
         hit <= 1'b0;
         if (consumed && (chk_q != last_code)) consumed <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  steps_lat <= (num_steps > SW'(DEPTH)) ? SW'(DEPTH) : num_steps;
                  state     <= ARMED;
                  busy      <= 1'b1;
                  pass      <= 1'b0;
                  fail      <= 1'b0;
                  step_idx  <= '0;
                  consumed  <= 1'b0;
               end
            end
            ARMED: begin
               if (steps_lat == '0) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  pass  <= 1'b1;
               end else begin
                  if (match) begin
                     hit       <= 1'b1;
                     step_idx  <= step_next;
                     consumed  <= 1'b1;
                     last_code <= chk_q;
                  end
                  // Completion wins over a timeout landing on the same edge.
                  if (match && (step_next == steps_lat)) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     pass  <= 1'b1;
                  end else if (expire) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     fail  <= 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/gpio_checkpoint_monitor.md
# gpio_checkpoint_monitor

- Synthesizable, parametrised checkpoint-sequence monitor for a WIDTH-bit status bus, such as the user-project `mprj_io[31:16]` checkbits.
- Holds a programmable table of up to DEPTH expected codes and requires them in order; 16'hAB60 then 16'hAB61 is the two-step case.
- Enforces a programmable global cycle timeout and reports pass/fail/progress as registered outputs.
- Sits in the user project area; a bench or the management SoC can read its verdict instead of relying on a behavioural `wait()`.

## Interface

Parameters:
- `WIDTH`, 16, width of monitored bus and of each expected code
- `DEPTH`, 4, number of checkpoint table entries (≥1)
- `TMO_W`, 32, width of timeout limit and cycle counter

Ports:
- `clock`  in  1  single clock
- `resetb`  in  1  synchronous, active-low reset
- `check_i`  in  WIDTH  monitored status bus; asynchronous to the producer's writes, sampled every cycle
- `start`  in  1  arm pulse; honoured only when not `busy`
- `num_steps`  in  $clog2(DEPTH+1)  number of table entries to match; sampled on accepted `start`
- `tmo_lim`  in  TMO_W  timeout in cycles, 0 = no timeout; sampled on accepted `start`
- `exp_we`  in  1  table write strobe
- `exp_addr`  in  $clog2(DEPTH)  table write index
- `exp_data`  in  WIDTH  table write data
- `busy`  out  1  monitor armed
- `pass`  out  1  sticky: all steps matched
- `fail`  out  1  sticky: timeout expired
- `hit`  out  1  one-cycle pulse per matched step
- `step_idx`  out  $clog2(DEPTH+1)  number of steps matched so far
- `cycles`  out  TMO_W  cycles elapsed since arm; frozen at completion

## Operation

- States: IDLE, ARMED, DONE.
- Reset (`resetb`=0 at a `clock` edge) forces IDLE and clears every output to 0: busy, pass, fail, hit, step_idx, cycles.
- Reset also clears the sample register. Table contents are not reset.
- Reset mid-ARMED aborts the run with no verdict.

Table writes:
- Accepted in IDLE or DONE.
- Ignored while `busy`.

IDLE/DONE + `start`:
- Latch `num_steps`, clamped to DEPTH, and `tmo_lim`.
- Clear pass, fail, step_idx and cycles.
- Enter ARMED.
- If the latched `num_steps` = 0: go straight to DONE with pass=1 on the next cycle.

ARMED:
- `cycles` increments each cycle, saturating at all-ones.
- The sampled bus is compared against `exp[step_idx]`. Any other value, including earlier codes, is ignored.
- On match: pulse hit and increment step_idx.
- If that match completes the last step: enter DONE, assert pass, deassert busy.
- Each step consumes one match. A held value cannot satisfy two consecutive identical entries until it changes away and back.
- Timeout: when `tmo_lim`≠0 and `cycles` reaches `tmo_lim` without completion, enter DONE with fail=1.
- A final-step match and timeout on the same cycle resolve to pass.

`start` while ARMED is ignored.

## Timing

- `check_i` is registered once into `chk_q`. The compare is registered.
- `hit` asserts 2 cycles after `check_i` first presents the expected code. `pass` and the `step_idx` update appear on the same edge as `hit`.
- `busy` rises 1 cycle after an accepted `start`.
- `fail` asserts on the edge where `cycles` becomes equal to `tmo_lim`.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration

`GPIO_CHKMON_STABLE_EN`:
- Defined: a step matches only when `chk_q` equals the expected code for 2 consecutive cycles. This rejects transient values while the multibit bus updates. Latency to `hit` becomes 3 cycles.
- Undefined: a single-cycle match suffices, and latency is 2 cycles.

## Structure

Package `gpio_chkmon_pkg`:
- state enum (IDLE, ARMED, DONE)
- `STABLE_CYCLES` constant (2)

Sub-module `gpio_chkmon_timer`:
- arm/freeze/saturating cycle counter plus limit compare
- instanced once

## Test plan

1. Table {AB60, AB61}, num_steps=2, tmo_lim=50000; drive AB60 at cycle 100 and AB61 at cycle 300 → hit at 102 and 302, pass=1, step_idx=2, cycles frozen, fail=0.
2. Same table; drive AB61 first, then AB60, then AB61 → the first AB61 is ignored; pass only after the second AB61.
3. tmo_lim=1000; drive only AB60 → fail=1 with cycles=1000, step_idx=1, pass=0.
4. Final match lands on the timeout cycle → pass=1, fail=0.
5. Table {0x5555, 0x5555}; hold 0x5555 → step_idx=1 only. Toggle to 0 and back → pass.
6. With `GPIO_CHKMON_STABLE_EN`: a 1-cycle AB60 glitch gives no hit, and a 2-cycle AB60 gives hit 3 cycles after onset. Also: `resetb`=0 mid-ARMED clears all outputs on the next edge, and `start` while busy is ignored.
